// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment decode constants and the nibble decoder.
//   SEG_0..SEG_F : active-high g..a patterns (bit 6 = g, bit 0 = a)
//   SEG_OFF      : all segments dark
//   hex_to_seg() : 4-bit nibble -> 7-bit active-high segment pattern
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        s = SEG_OFF;
        case (nibble)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            4'hF: s = SEG_F;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running modulo-DIV counter with a one-cycle tick at
// its terminal count (DIV-1). DIV=1 gives a tick on every cycle.
//   clk  : clock
//   rst  : synchronous active-high reset (counter -> 0)
//   tick : high for the whole cycle in which the counter holds DIV-1
module tick_divider #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed N-digit seven-segment driver.
//   clk, rst     : clock, synchronous active-high reset
//   digits       : packed nibbles, digit 0 = digits[3:0] (rightmost)
//   dp_mask      : per-digit decimal point enable
//   blank_mask   : per-digit force-dark
//   blink_mask   : per-digit blink enable; blink_all blinks every digit
//   lz_suppress  : darken leading zero digits (digit 0 always shown)
//   seg          : {dp, g..a}, registered, in ACTIVE_LOW polarity
//   an           : one-hot digit enable, registered, same polarity
// seg and an are loaded together on the refresh tick edge, so the anode
// and its segment image can never be skewed.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blink_all,
    input  logic                  lz_suppress,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an
);

    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam bit POL = (ACTIVE_LOW != 0);

    // Inactive levels: an XOR with all-ones when pins are active-low.
    localparam logic [7:0]          SEG_INACT = {8{POL}};
    localparam logic [N_DIGITS-1:0] AN_INACT  = {N_DIGITS{POL}};

    logic refresh_tick;
    logic blink_tick;
    logic blink_phase;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .tick (refresh_tick)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .tick (blink_tick)
    );

    // Phase 0 = visible, 1 = blinking digits dark.
    always_ff @(posedge clk) begin
        if (rst)             blink_phase <= 1'b0;
        else if (blink_tick) blink_phase <= ~blink_phase;
    end

    // ------------------------------------------------------------------
    // Scan index
    // ------------------------------------------------------------------
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;

    always_comb begin
        idx_next = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)               idx <= IW'(N_DIGITS - 1);
        else if (refresh_tick) idx <= idx_next;
    end

    // ------------------------------------------------------------------
    // Per-digit active-high images
    // ------------------------------------------------------------------
    // nz_chain[i] = any nibble in i..N_DIGITS-1 is non-zero; a digit is a
    // leading zero exactly when that prefix OR is clear.
    logic [N_DIGITS:0]          nz_chain;
    logic [N_DIGITS-1:0][7:0]   img;

    assign nz_chain[N_DIGITS] = 1'b0;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic [3:0] nib;
        logic       lz_dark;
        logic       dark;

        assign nib         = digits[4*i +: 4];
        assign nz_chain[i] = (nib != 4'h0) | nz_chain[i+1];
        assign lz_dark     = (i != 0) & lz_suppress & ~nz_chain[i];
        assign dark        = blank_mask[i]
                           | ((blink_mask[i] | blink_all) & blink_phase)
                           | lz_dark;
        assign img[i]      = dark ? 8'h00 : {dp_mask[i], hex_to_seg(nib)};
    end

    // ------------------------------------------------------------------
    // Select image and anode for the digit being loaded next
    // ------------------------------------------------------------------
    logic [7:0]          seg_sel;
    logic [N_DIGITS-1:0] an_sel;

    always_comb begin
        seg_sel = 8'h00;
        an_sel  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                seg_sel   = img[i];
                an_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_INACT;
            an  <= AN_INACT;
        end else if (refresh_tick) begin
            seg <= seg_sel ^ SEG_INACT;
            an  <= an_sel ^ AN_INACT;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: scoreboard bench for seg_scan_display
// (N_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=32, ACTIVE_LOW=1).
// A cycle model keyed on "edges since reset" predicts {an, seg} after
// every clock edge and queues it; a monitor pops and compares on the
// falling edge. A few fixed-value checks anchor the reset and first-frame
// timing.
module tb_seg_scan_display;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 32;

    localparam logic [6:0] DEC [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic         clk;
    logic         rst;
    logic [15:0]  digits;
    logic [3:0]   dp_mask;
    logic [3:0]   blank_mask;
    logic [3:0]   blink_mask;
    logic         blink_all;
    logic         lz_suppress;
    logic [7:0]   seg;
    logic [3:0]   an;

    int n_chk  = 0;
    int n_pass = 0;

    seg_scan_display #(
        .N_DIGITS    (N),
        .REFRESH_DIV (R),
        .BLINK_DIV   (B),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .blink_all   (blink_all),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Model: k = index of this edge among edges since reset released.
    // Tick edges are those with k % R == R-1; they present digit
    // (k/R) % N using the blink phase in force before the edge.
    // ------------------------------------------------------------------
    function automatic logic [11:0] model_next(
        input int k, input logic [11:0] prev, input logic [15:0] dg,
        input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk,
        input logic ba, input logic lz);
        int         d;
        logic       ph;
        logic       dark;
        logic [7:0] im;
        logic [3:0] a;
        if (k % R != R - 1) return prev;
        d    = (k / R) % N;
        ph   = ((k / B) % 2) == 1;
        dark = bl[d] | ((bk[d] | ba) & ph) | (lz && d != 0 && (dg >> (4*d)) == 16'h0);
        im   = dark ? 8'h00 : {dp[d], DEC[dg[4*d +: 4]]};
        a    = 4'b0001 << d;
        return {~a, ~im};
    endfunction

    int          m_t;
    logic [11:0] m_exp;
    logic [11:0] m_nxt;
    logic [11:0] sb_q [$];

    assign m_nxt = model_next(m_t, m_exp, digits, dp_mask, blank_mask,
                              blink_mask, blink_all, lz_suppress);

    always @(posedge clk) begin
        if (rst) begin
            m_t   <= 0;
            m_exp <= 12'hFFF;
            sb_q.push_back(12'hFFF);
        end else begin
            m_t   <= m_t + 1;
            m_exp <= m_nxt;
            sb_q.push_back(m_nxt);
        end
    end

    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_an", {28'h0, an}, {28'h0, e[11:8]});
                chk("sb_seg", {24'h0, seg}, {24'h0, e[7:0]});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Release reset, then confirm three dark cycles and digit 0 on the
    // fourth edge.
    task automatic release_and_check_first_tick();
        rst = 1'b0;
        for (int c = 0; c < R - 1; c++) begin
            step();
            chk("pre_tick_seg", {24'h0, seg}, 32'hFF);
            chk("pre_tick_an", {28'h0, an}, 32'hF);
        end
        step();
        chk("first_tick_an", {28'h0, an}, 32'hE);
    endtask

    localparam logic [3:0] EXP_AN   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] EXP_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        bit found;
        rst         = 1'b1;
        digits      = 16'h1234;
        dp_mask     = 4'h0;
        blank_mask  = 4'h0;
        blink_mask  = 4'h0;
        blink_all   = 1'b0;
        lz_suppress = 1'b0;
        step();
        step();
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_an", {28'h0, an}, 32'hF);

        // First frame of 1234, fixed expectations.
        rst = 1'b0;
        for (int c = 0; c < R - 1; c++) begin
            step();
            chk("init_seg", {24'h0, seg}, 32'hFF);
            chk("init_an", {28'h0, an}, 32'hF);
        end
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < R; c++) begin
                step();
                chk("f1234_an", {28'h0, an}, {28'h0, EXP_AN[d]});
                chk("f1234_seg", {24'h0, seg}, {24'h0, EXP_1234[d]});
            end
        end

        // Leading-zero suppression.
        digits = 16'h00A0; lz_suppress = 1'b1; run(40);
        lz_suppress = 1'b0;                    run(20);
        digits = 16'h0009; lz_suppress = 1'b1; run(20);
        digits = 16'h0000;                     run(20);

        // Blink-all with a decimal point, then blank + per-digit blink.
        digits = 16'h1234; lz_suppress = 1'b0;
        blink_all = 1'b1; dp_mask = 4'b0100;   run(140);
        blink_all = 1'b0; dp_mask = 4'b0000;
        blank_mask = 4'b1000; blink_mask = 4'b0001; run(140);

        // Reset during digit 2's hold.
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            step();
            if (an == 4'b1011) found = 1'b1;
        end
        chk("wait_digit2", {31'h0, found}, 32'h1);
        step();
        rst = 1'b1;
        step();
        chk("midrst_seg", {24'h0, seg}, 32'hFF);
        chk("midrst_an", {28'h0, an}, 32'hF);
        release_and_check_first_tick();
        run(20);

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
